// File: rtl/mem_region_decoder.sv
// mem_region_decoder: registered address decoder and access sequencer that sits
// between the core load/store port and the memory-mapped slaves. It accepts one
// request at a time, picks the lowest-indexed matching base/mask window, drives a
// one-hot select with a region-relative offset, and waits for the selected slave's
// ack. Every accepted request gets exactly one response. Unmapped, misaligned and
// timed-out accesses complete with an error instead of stalling the core.
module mem_region_decoder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int N_REGIONS      = 5,
  parameter logic [N_REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
    {32'h0000100C, 32'h00001008, 32'h00001004, 32'h00001000, 32'h00000000},
  parameter logic [N_REGIONS*ADDR_WIDTH-1:0] REGION_MASK =
    {{4{32'hFFFFFFFC}}, 32'hFFFFF000},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           m_req_valid,
  output logic                           m_req_ready,
  input  logic                           m_we,
  input  logic [ADDR_WIDTH-1:0]          m_addr,
  input  logic [DATA_WIDTH-1:0]          m_wdata,
  input  logic [DATA_WIDTH/8-1:0]        m_be,
  output logic                           m_rsp_valid,
  output logic [DATA_WIDTH-1:0]          m_rsp_rdata,
  output logic                           m_rsp_err,
  output logic [N_REGIONS-1:0]           s_sel,
  output logic                           s_we,
  output logic [ADDR_WIDTH-1:0]          s_addr,
  output logic [DATA_WIDTH-1:0]          s_wdata,
  output logic [DATA_WIDTH/8-1:0]        s_be,
  input  logic [N_REGIONS-1:0]           s_ack,
  input  logic [N_REGIONS*DATA_WIDTH-1:0] s_rdata
);

  localparam int BE_WIDTH   = DATA_WIDTH / 8;
  localparam int WORD_ALIGN = $clog2(BE_WIDTH);
  localparam int IDX_WIDTH  = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  // Low address bits that must be zero for a word-aligned access.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << WORD_ALIGN) - 64'd1);
  // The timeout fires on the edge that closes the (TIMEOUT_CYCLES+1)-th select
  // cycle, so the response lands TIMEOUT_CYCLES+1 cycles after s_sel rises.
  localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic                 TO_EN    = (TIMEOUT_CYCLES != 0) ? 1'b1 : 1'b0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]              state_r;
  logic                    ready_r;
  logic                    rsp_valid_r;
  logic                    rsp_err_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic [N_REGIONS-1:0]    sel_r;
  logic                    we_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [BE_WIDTH-1:0]     be_r;
  logic [IDX_WIDTH-1:0]    idx_r;
  logic [CNT_WIDTH-1:0]    cnt_r;

  logic                    hit_s;
  logic [IDX_WIDTH-1:0]    hit_idx_s;
  logic [N_REGIONS-1:0]    hit_onehot_s;
  logic [ADDR_WIDTH-1:0]   hit_off_s;
  logic                    misalign_s;
  logic                    ack_s;
  logic [DATA_WIDTH-1:0]   ack_rdata_s;
  logic                    timeout_s;

  // True when addr falls inside the window described by base/mask.
  function automatic logic region_match(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [ADDR_WIDTH-1:0] base,
                                        input logic [ADDR_WIDTH-1:0] mask);
    return ((addr & mask) == (base & mask)) ? 1'b1 : 1'b0;
  endfunction

  // Window decode: scan from the top so the lowest matching index wins.
  always_comb begin
    hit_s        = 1'b0;
    hit_idx_s    = '0;
    hit_onehot_s = '0;
    hit_off_s    = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (region_match(m_addr, REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH],
                       REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit_s           = 1'b1;
        hit_idx_s       = IDX_WIDTH'(i);
        hit_onehot_s    = '0;
        hit_onehot_s[i] = 1'b1;
        hit_off_s       = m_addr & ~REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
      end else begin
        hit_s        = hit_s;
        hit_idx_s    = hit_idx_s;
        hit_onehot_s = hit_onehot_s;
        hit_off_s    = hit_off_s;
      end
    end
  end

  assign misalign_s = |(m_addr & ALIGN_MASK);

  // Pick the ack and read data of the latched slave only; other acks are ignored.
  always_comb begin
    ack_s       = 1'b0;
    ack_rdata_s = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (idx_r == IDX_WIDTH'(i)) begin
        ack_s       = s_ack[i];
        ack_rdata_s = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        ack_s       = ack_s;
        ack_rdata_s = ack_rdata_s;
      end
    end
  end

  assign timeout_s = TO_EN && (cnt_r == TO_LAST);

  // Request/response sequencer: IDLE accepts, ACCESS waits for ack or timeout,
  // RESP emits the single-cycle response strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= '0;
      sel_r       <= '0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      be_r        <= '0;
      idx_r       <= '0;
      cnt_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (m_req_valid && ready_r) begin
            ready_r <= 1'b0;
            if (hit_s && !misalign_s) begin
              state_r <= ST_ACCESS;
              sel_r   <= hit_onehot_s;
              we_r    <= m_we;
              addr_r  <= hit_off_s;
              wdata_r <= m_wdata;
              be_r    <= m_be;
              idx_r   <= hit_idx_s;
              cnt_r   <= '0;
            end else begin
              // Decode error: respond at once and leave the slave bus idle.
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= '0;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (ack_s) begin
            // Ack wins over a timeout landing on the same edge.
            state_r     <= ST_RESP;
            sel_r       <= '0;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= we_r ? '0 : ack_rdata_s;
          end else if (timeout_s) begin
            state_r     <= ST_RESP;
            sel_r       <= '0;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_rdata_r <= '0;
          end else if (TO_EN) begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_RESP: begin
          state_r     <= ST_IDLE;
          ready_r     <= 1'b1;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= '0;
          sel_r       <= '0;
        end
        default: begin
          state_r     <= ST_IDLE;
          ready_r     <= 1'b1;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= '0;
          sel_r       <= '0;
        end
      endcase
    end
  end

  assign m_req_ready = ready_r;
  assign m_rsp_valid = rsp_valid_r;
  assign m_rsp_err   = rsp_err_r;
  assign m_rsp_rdata = rsp_rdata_r;
  assign s_sel       = sel_r;
  assign s_we        = we_r;
  assign s_addr      = addr_r;
  assign s_wdata     = wdata_r;
  assign s_be        = be_r;

endmodule

// File: tb/tb_mem_region_decoder.sv
// Directed bench for mem_region_decoder: expected responses are queued when a
// request is driven and popped when the decoder strobes m_rsp_valid.
module tb_mem_region_decoder;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         m_req_valid, m_req_ready, m_we;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_be;
  logic         m_rsp_valid, m_rsp_err;
  logic [31:0]  m_rsp_rdata;
  logic [4:0]   s_sel, s_ack;
  logic         s_we;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_be;
  logic [159:0] s_rdata;

  // Second instance: two overlapping windows, short timeout.
  logic         m2_req_valid, m2_req_ready, m2_rsp_valid, m2_rsp_err, s2_we;
  logic [31:0]  m2_addr, m2_rsp_rdata, s2_addr, s2_wdata;
  logic [3:0]   s2_be;
  logic [1:0]   s2_sel, s2_ack;
  logic [63:0]  s2_rdata;

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];

  mem_region_decoder dut (
    .clk(clk), .rst(rst),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  mem_region_decoder #(
    .N_REGIONS(2),
    .REGION_BASE({32'h00001000, 32'h00001000}),
    .REGION_MASK({32'hFFFFFFFC, 32'hFFFFF000}),
    .TIMEOUT_CYCLES(4)
  ) dut2 (
    .clk(clk), .rst(rst),
    .m_req_valid(m2_req_valid), .m_req_ready(m2_req_ready), .m_we(1'b0),
    .m_addr(m2_addr), .m_wdata(32'h0), .m_be(4'hF),
    .m_rsp_valid(m2_rsp_valid), .m_rsp_rdata(m2_rsp_rdata), .m_rsp_err(m2_rsp_err),
    .s_sel(s2_sel), .s_we(s2_we), .s_addr(s2_addr), .s_wdata(s2_wdata), .s_be(s2_be),
    .s_ack(s2_ack), .s_rdata(s2_rdata)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single accepting edge, then drop valid.
  task automatic send(input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
    m_req_valid = 1'b1;
    m_we        = we;
    m_addr      = addr;
    m_wdata     = wdata;
    m_be        = be;
    tick();
    m_req_valid = 1'b0;
  endtask

  // Wait (bounded) for the response strobe, check latency, compare with scoreboard.
  task automatic wait_rsp(input string tag, input int exp_wait);
    int   n;
    rsp_t e;
    n = 0;
    while (m_rsp_valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_wait));
    chk({tag, "_valid"}, {63'd0, m_rsp_valid}, 64'd1);
    chk({tag, "_sb_entry"}, {63'd0, exp_q.size() != 0}, 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_err"}, {63'd0, m_rsp_err}, {63'd0, e.err});
      chk({tag, "_rdata"}, {32'd0, m_rsp_rdata}, {32'd0, e.rdata});
    end else begin
      n = n;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, {63'd0, m_req_ready}, 64'd1);
    chk({tag, "_rsp_valid"}, {63'd0, m_rsp_valid}, 64'd0);
    chk({tag, "_rsp_err"}, {63'd0, m_rsp_err}, 64'd0);
    chk({tag, "_rsp_rdata"}, {32'd0, m_rsp_rdata}, 64'd0);
    chk({tag, "_s_sel"}, {59'd0, s_sel}, 64'd0);
    chk({tag, "_s_we"}, {63'd0, s_we}, 64'd0);
    chk({tag, "_s_addr"}, {32'd0, s_addr}, 64'd0);
    chk({tag, "_s_wdata"}, {32'd0, s_wdata}, 64'd0);
    chk({tag, "_s_be"}, {60'd0, s_be}, 64'd0);
  endtask

  initial begin
    int n2;
    rst = 1'b1;
    m_req_valid = 1'b0; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0;
    s_ack = 5'b0; s_rdata = '0;
    m2_req_valid = 1'b0; m2_addr = 32'h0; s2_ack = 2'b0; s2_rdata = '0;
    tick(); tick();
    chk_reset_state("reset");
    chk("reset_dut2_sel", {62'd0, s2_sel}, 64'd0);
    rst = 1'b0;
    tick();

    // Read region 2, slave acks in the third select cycle.
    exp_q.push_back('{err: 1'b0, rdata: 32'hA5A50003});
    send(1'b0, 32'h00001004, 32'h0, 4'hF);
    chk("rd_sel", {59'd0, s_sel}, 64'h04);
    chk("rd_saddr", {32'd0, s_addr}, 64'h0);
    chk("rd_ready_busy", {63'd0, m_req_ready}, 64'd0);
    tick(); tick();
    s_rdata[2*32 +: 32] = 32'hA5A50003;
    s_ack = 5'b00100;
    wait_rsp("rd_slave2", 1);
    s_ack = 5'b0;
    tick();
    chk("rd_strobe_one_cycle", {63'd0, m_rsp_valid}, 64'd0);
    chk("rd_ready_again", {63'd0, m_req_ready}, 64'd1);

    // Write region 0 with immediate ack; slave read data must not leak out.
    exp_q.push_back('{err: 1'b0, rdata: 32'h0});
    send(1'b1, 32'h00000F00, 32'hDEADBEEF, 4'hF);
    chk("wr_sel", {59'd0, s_sel}, 64'h01);
    chk("wr_saddr", {32'd0, s_addr}, 64'hF00);
    chk("wr_swdata", {32'd0, s_wdata}, 64'hDEADBEEF);
    chk("wr_swe", {63'd0, s_we}, 64'd1);
    chk("wr_sbe", {60'd0, s_be}, 64'hF);
    s_rdata[0 +: 32] = 32'h12345678;
    s_ack = 5'b00001;
    wait_rsp("wr_slave0", 1);
    s_ack = 5'b0;
    tick();
    chk("wr_ready_again", {63'd0, m_req_ready}, 64'd1);

    // Unmapped address.
    exp_q.push_back('{err: 1'b1, rdata: 32'h0});
    send(1'b0, 32'h00002000, 32'h0, 4'hF);
    wait_rsp("unmapped", 0);
    chk("unmapped_sel", {59'd0, s_sel}, 64'd0);
    tick();

    // Misaligned address inside region 1's window.
    exp_q.push_back('{err: 1'b1, rdata: 32'h0});
    send(1'b0, 32'h00001002, 32'h0, 4'hF);
    wait_rsp("misalign", 0);
    chk("misalign_sel", {59'd0, s_sel}, 64'd0);
    tick();

    // Timeout: no ack from region 3.
    exp_q.push_back('{err: 1'b1, rdata: 32'h0});
    send(1'b0, 32'h00001008, 32'h0, 4'hF);
    chk("to_sel", {59'd0, s_sel}, 64'h08);
    wait_rsp("timeout", 256);
    tick();
    chk("to_ready_after", {63'd0, m_req_ready}, 64'd1);

    // Foreign ack and held request during ACCESS, then reset mid-access.
    send(1'b0, 32'h00001008, 32'h0, 4'hF);
    chk("rst_acc_sel", {59'd0, s_sel}, 64'h08);
    m_req_valid = 1'b1;
    m_addr = 32'h00001004;
    s_ack = 5'b00010;
    tick();
    chk("foreign_ack_no_rsp", {63'd0, m_rsp_valid}, 64'd0);
    chk("foreign_ack_sel_held", {59'd0, s_sel}, 64'h08);
    chk("held_req_not_ready", {63'd0, m_req_ready}, 64'd0);
    s_ack = 5'b0;
    rst = 1'b1;
    tick();
    chk_reset_state("midrst");
    m_req_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_rsp", {63'd0, m_rsp_valid}, 64'd0);
    end

    // Overlapping windows: region 0 wins; its 4-cycle timeout fires 5 cycles after select.
    m2_req_valid = 1'b1;
    m2_addr = 32'h00001000;
    tick();
    m2_req_valid = 1'b0;
    chk("ovl_sel", {62'd0, s2_sel}, 64'h1);
    chk("ovl_saddr", {32'd0, s2_addr}, 64'h0);
    n2 = 0;
    while (m2_rsp_valid !== 1'b1 && n2 < 50) begin
      tick();
      n2++;
    end
    chk("ovl_to_latency", 64'(n2), 64'd5);
    chk("ovl_to_err", {63'd0, m2_rsp_err}, 64'd1);
    chk("ovl_to_rdata", {32'd0, m2_rsp_rdata}, 64'd0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
